error_gen: RTL and testbench

ERROR_GEN -- requirements
Module: error_gen

---
 rtl/error_gen_pkg.sv | 14 +
 rtl/error_gen_err_pattern.sv | 76 +++++++
 rtl/error_gen.sv | 136 +++++++++++++
 tb/tb_error_gen.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/error_gen_pkg.sv
// Shared definitions for the error_gen block and its bench: FSM state
// encoding and the default window length / detector tolerance.
package error_gen_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int N_DEF = 64;
    localparam int H_DEF = 8;

endpackage

// File: rtl/error_gen_err_pattern.sv
// err_pattern: walks the bit index of one window and decides, bit by bit,
// whether the current position carries an injected error.  Errors sit at
// 0, stride, 2*stride, ... up to k of them, and anything landing at or past
// the window end is simply never reached (no wrap into the next window).
module err_pattern #(
    parameter int N = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   adv,
    input  logic                   clear,
    input  logic [$clog2(N):0]     k,
    input  logic [$clog2(N)-1:0]   stride,
    output logic                   bit_out,
    output logic [$clog2(N)-1:0]   bit_idx
);

    localparam int IW = $clog2(N);
    localparam int KW = IW + 1;

    logic [IW-1:0] idx_q, idx_d;
    logic [KW-1:0] nxt_q, nxt_d;
    logic [KW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;
    logic          hit;

    // Next bit: restart at index 0 on load or window wrap, otherwise step and test for an error.
    always_comb begin
        idx_d = idx_q;
        nxt_d = nxt_q;
        cnt_d = cnt_q;
        out_d = out_q;
        hit   = 1'b0;
        if (clear) begin
            idx_d = '0;
            nxt_d = '0;
            cnt_d = '0;
            out_d = 1'b0;
        end else if (load || (adv && (idx_q == IW'(N - 1)))) begin
            // Index 0 always carries the first error when k is non-zero.
            idx_d = '0;
            out_d = (k != '0);
            cnt_d = (k != '0) ? KW'(1) : '0;
            nxt_d = KW'(stride);
        end else if (adv) begin
            idx_d = idx_q + IW'(1);
            hit   = (cnt_q < k) && (nxt_q == (KW'(idx_q) + KW'(1)));
            out_d = hit;
            if (hit) begin
                cnt_d = cnt_q + KW'(1);
                // nxt_q <= N-1 here, so the sum stays below 2N and fits KW bits.
                nxt_d = nxt_q + KW'(stride);
            end
        end
    end

    // Pattern state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q <= '0;
            nxt_q <= '0;
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            nxt_q <= nxt_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign bit_out = out_q;
    assign bit_idx = idx_q;

endmodule

// File: rtl/error_gen.sv
// error_gen: emits windows*N serial bits with k errors per window spaced
// stride apart, for exercising a paired error detector.  The FSM and the
// window counter live here; the per-window pattern lives in err_pattern.
module error_gen
    import error_gen_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int H = H_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [$clog2(N):0]     err_k,
    input  logic [$clog2(N)-1:0]   stride,
    input  logic [7:0]             windows,
    output logic                   out,
    output logic [$clog2(N)-1:0]   bit_idx,
    output logic                   busy,
    output logic                   done,
    output logic                   warn_level
);

    localparam int IW = $clog2(N);
    localparam int KW = IW + 1;

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [IW-1:0] stride_q, stride_d;
    logic [7:0]    win_tot_q, win_tot_d;
    logic [7:0]    win_cnt_q, win_cnt_d;
    logic          warn_q, warn_d;

    logic [KW-1:0] k_eff;
    logic [IW-1:0] stride_eff;
    logic [7:0]    win_eff;
    logic          load, adv, clear, last_bit;
    logic [KW-1:0] pat_k;
    logic [IW-1:0] pat_stride;

    // Sanitised run parameters: k clamped to N, zero stride/windows promoted to 1.
    always_comb begin
        k_eff      = (err_k > KW'(N)) ? KW'(N) : err_k;
        stride_eff = (stride == '0) ? IW'(1) : stride;
        win_eff    = (windows == 8'd0) ? 8'd1 : windows;
        last_bit   = (bit_idx == IW'(N - 1)) && (win_cnt_q == (win_tot_q - 8'd1));
    end

    // FSM next state, latched parameters and pattern control.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        stride_d  = stride_q;
        win_tot_d = win_tot_q;
        win_cnt_d = win_cnt_q;
        warn_d    = warn_q;
        load      = 1'b0;
        adv       = 1'b0;
        clear     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    k_d       = k_eff;
                    stride_d  = stride_eff;
                    win_tot_d = win_eff;
                    win_cnt_d = 8'd0;
                    warn_d    = (int'(k_eff) >= H);
                    load      = 1'b1;
                end
            end
            S_RUN: begin
                if (last_bit) begin
                    state_d = S_DONE;
                    warn_d  = 1'b0;
                    clear   = 1'b1;
                end else begin
                    adv = 1'b1;
                    if (bit_idx == IW'(N - 1)) begin
                        win_cnt_d = win_cnt_q + 8'd1;
                    end
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                win_cnt_d = 8'd0;
            end
            default: begin
                state_d = S_IDLE;
                warn_d  = 1'b0;
                clear   = 1'b1;
            end
        endcase
    end

    // The first window uses the just-sanitised inputs; later windows use the latched copies.
    always_comb begin
        pat_k      = load ? k_eff : k_q;
        pat_stride = load ? stride_eff : stride_q;
    end

    // Control and latched-parameter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            stride_q  <= '0;
            win_tot_q <= 8'd0;
            win_cnt_q <= 8'd0;
            warn_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            stride_q  <= stride_d;
            win_tot_q <= win_tot_d;
            win_cnt_q <= win_cnt_d;
            warn_q    <= warn_d;
        end
    end

    err_pattern #(.N(N)) u_pattern (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .adv     (adv),
        .clear   (clear),
        .k       (pat_k),
        .stride  (pat_stride),
        .bit_out (out),
        .bit_idx (bit_idx)
    );

    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign warn_level = warn_q;

endmodule

// File: tb/tb_error_gen.sv
// Bench for error_gen: expected {warn, out, bit_idx} per cycle are queued
// when a run is started and popped as the DUT emits bits.
module tb_error_gen;
    import error_gen_pkg::*;

    localparam int N  = N_DEF;
    localparam int H  = H_DEF;
    localparam int IW = $clog2(N);
    localparam int KW = IW + 1;

    logic          clock;
    logic          reset;
    logic          start;
    logic [KW-1:0] err_k;
    logic [IW-1:0] stride;
    logic [7:0]    windows;
    logic          out;
    logic [IW-1:0] bit_idx;
    logic          busy;
    logic          done;
    logic          warn_level;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    error_gen #(.N(N), .H(H)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .err_k      (err_k),
        .stride     (stride),
        .windows    (windows),
        .out        (out),
        .bit_idx    (bit_idx),
        .busy       (busy),
        .done       (done),
        .warn_level (warn_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk_val(input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference pattern: index i is an error iff i is a multiple of the
    // stride and fewer than k multiples precede it.
    task automatic push_expect(input int k, input int s, input int w);
        int kk, ss, ww, wr;
        kk = (k > N) ? N : k;
        ss = (s == 0) ? 1 : s;
        ww = (w == 0) ? 1 : w;
        wr = (kk >= H) ? 1 : 0;
        for (int win = 0; win < ww; win++) begin
            for (int i = 0; i < N; i++) begin
                int e;
                e = ((i % ss) == 0 && (i / ss) < kk) ? 1 : 0;
                exp_q.push_back((wr << 16) | (e << 8) | i);
            end
        end
    endtask

    task automatic pop_compare();
        int e;
        e = exp_q.pop_front();
        chk_val("out", int'(out), (e >> 8) & 1);
        chk_val("bit_idx", int'(bit_idx), e & 8'hff);
        chk_val("warn_level", int'(warn_level), (e >> 16) & 1);
    endtask

    task automatic run_case(input int k, input int s, input int w, input int mid);
        int ww, budget, busy_cnt;
        bit got_done;
        ww       = (w == 0) ? 1 : w;
        budget   = ww * N + 4;
        busy_cnt = 0;
        got_done = 1'b0;
        push_expect(k, s, w);
        @(negedge clock);
        err_k   = KW'(k);
        stride  = IW'(s);
        windows = 8'(w);
        start   = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk_val("busy_first", int'(busy), 1);
        for (int c = 0; c < budget && !got_done; c++) begin
            if (busy) begin
                if (exp_q.size() > 0) pop_compare();
                busy_cnt++;
            end else if (done) begin
                got_done = 1'b1;
            end
            if (c == mid) begin
                start   = 1'b1;
                err_k   = KW'(50);
                stride  = IW'(1);
                windows = 8'd9;
            end else begin
                start = 1'b0;
            end
            if (!got_done) @(negedge clock);
        end
        start = 1'b0;
        chk_val("done_seen", int'(got_done), 1);
        chk_val("busy_cycles", busy_cnt, ww * N);
        chk_val("queue_left", exp_q.size(), 0);
        exp_q.delete();
        if (got_done) begin
            chk_val("done_out", int'(out), 0);
            chk_val("done_idx", int'(bit_idx), 0);
            chk_val("done_warn", int'(warn_level), 0);
            @(negedge clock);
            chk_val("done_single", int'(done), 0);
            chk_val("idle_busy", int'(busy), 0);
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b1;
        err_k   = KW'(5);
        stride  = IW'(1);
        windows = 8'd1;
        repeat (3) @(negedge clock);
        chk_val("rst_busy", int'(busy), 0);
        chk_val("rst_done", int'(done), 0);
        chk_val("rst_out", int'(out), 0);
        chk_val("rst_idx", int'(bit_idx), 0);
        chk_val("rst_warn", int'(warn_level), 0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        chk_val("rst_start_ignored", int'(busy), 0);

        run_case(8, 1, 1, -1);     // burst
        run_case(4, 16, 2, -1);    // spread over two windows
        run_case(10, 10, 1, -1);   // overflow: errors past N dropped
        run_case(0, 5, 0, -1);     // k=0, windows=0 -> one zero window
        run_case(100, 1, 1, -1);   // k clamped to N: all ones
        run_case(3, 0, 1, -1);     // stride 0 behaves as 1
        run_case(3, 7, 2, 20);     // start mid-run is ignored

        // Reset in the middle of a run aborts it with no done pulse.
        push_expect(3, 5, 2);
        @(negedge clock);
        err_k   = KW'(3);
        stride  = IW'(5);
        windows = 8'd2;
        start   = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            chk_val("abort_busy", int'(busy), 1);
            if (exp_q.size() > 0) pop_compare();
            @(negedge clock);
        end
        reset = 1'b1;
        @(negedge clock);
        chk_val("abort_busy0", int'(busy), 0);
        chk_val("abort_done0", int'(done), 0);
        chk_val("abort_out0", int'(out), 0);
        chk_val("abort_idx0", int'(bit_idx), 0);
        chk_val("abort_warn0", int'(warn_level), 0);
        reset = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            chk_val("abort_no_done", int'(done), 0);
            chk_val("abort_idle", int'(busy), 0);
        end

        run_case(2, 30, 1, -1);    // normal run after abort

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
